// File: rtl/voq_reader.sv
// voq_reader: ingress-buffer read side; dequeues a VOQ head, walks its 8-word block chain and streams it.
// Optional statistics counters (stat_pkts, stat_words, stat_err) are built when VOQ_READER_STATS_EN is defined.
module voq_reader #(
  parameter int EGRESS_CNT = 4,
  parameter int ADDR_W     = 13,
  localparam int SEL_W     = $clog2(EGRESS_CNT),
  localparam int BLK_W     = ADDR_W - 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant_valid,
  input  logic [SEL_W-1:0]  grant_sel,
  output logic              grant_ready,
  output logic              grant_err,
  output logic              voq_dequeue_en,
  output logic [SEL_W-1:0]  voq_dequeue_sel,
  input  logic              voq_is_empty,
  input  logic [ADDR_W-1:0] voq_meta,
  output logic [ADDR_W-1:0] dmem_ra,
  input  logic [31:0]       dmem_q,
  output logic [ADDR_W-1:0] cmu_free_addr,
  input  logic [ADDR_W-1:0] cmu_next_addr,
  output logic              cmu_free_en,
  output logic [31:0]       packet_out,
  output logic              packet_out_en,
  output logic              packet_out_sop,
  output logic              packet_out_eop
`ifdef VOQ_READER_STATS_EN
  ,
  output logic [31:0]       stat_pkts,
  output logic [31:0]       stat_words,
  output logic [15:0]       stat_err
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DEQ   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [2:0]       state_q,   state_d;
  logic [BLK_W-1:0] cur_blk_q, cur_blk_d;
  logic [5:0]       rd_cnt_q,  rd_cnt_d;
  logic [5:0]       len_q,     len_d;
  logic             out_en_q,  out_en_d;
  logic             sop_q,     sop_d;
  logic             eop_q,     eop_d;

  logic [5:0] len_eff;
  logic       last_word;

  // Offset bits of head/next pointers are ignored: blocks always start at offset 0.
  logic unused_low_bits;
  assign unused_low_bits = ^{voq_meta[2:0], cmu_next_addr[2:0]};

  // A header length below one block still reads the whole first block.
  assign len_eff   = (len_q < 6'd8) ? 6'd8 : len_q;
  // Before the header returns len_q is stale, but len_eff-1 >= 7 so the
  // compare cannot fire on the first two reads.
  assign last_word = (rd_cnt_q == (len_eff - 6'd1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d         = state_q;
    cur_blk_d       = cur_blk_q;
    rd_cnt_d        = rd_cnt_q;
    len_d           = len_q;
    out_en_d        = 1'b0;
    sop_d           = 1'b0;
    eop_d           = 1'b0;
    grant_ready     = 1'b0;
    grant_err       = 1'b0;
    voq_dequeue_en  = 1'b0;
    voq_dequeue_sel = '0;
    dmem_ra         = '0;
    cmu_free_addr   = '0;
    cmu_free_en     = 1'b0;

    // Header word is on dmem_q in the cycle its sop is presented.
    if (out_en_q && sop_q) begin
      len_d = dmem_q[26:21];
    end

    case (state_q)
      ST_IDLE: begin
        grant_ready     = 1'b1;
        voq_dequeue_sel = grant_sel;
        if (grant_valid) begin
          if (voq_is_empty) begin
            grant_err = 1'b1;
          end else begin
            voq_dequeue_en = 1'b1;
            state_d        = ST_DEQ;
          end
        end
      end

      ST_DEQ: begin
        cur_blk_d = voq_meta[ADDR_W-1:3];
        rd_cnt_d  = '0;
        state_d   = ST_LOAD;
      end

      ST_LOAD, ST_READ: begin
        dmem_ra       = {cur_blk_q, rd_cnt_q[2:0]};
        cmu_free_addr = {cur_blk_q, 3'b000};
        rd_cnt_d      = rd_cnt_q + 6'd1;
        out_en_d      = 1'b1;
        sop_d         = (state_q == ST_LOAD);
        state_d       = ST_READ;
        if (last_word) begin
          cmu_free_en = 1'b1;
          eop_d       = 1'b1;
          state_d     = ST_DRAIN;
        end else if (rd_cnt_q[2:0] == 3'd7) begin
          cmu_free_en = 1'b1;
          cur_blk_d   = cmu_next_addr[ADDR_W-1:3];
        end
      end

      ST_DRAIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cur_blk_q <= '0;
      rd_cnt_q  <= '0;
      len_q     <= '0;
      out_en_q  <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_blk_q <= cur_blk_d;
      rd_cnt_q  <= rd_cnt_d;
      len_q     <= len_d;
      out_en_q  <= out_en_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
    end
  end

  // dmem_q is already registered by the memory, so data passes straight through.
  assign packet_out     = out_en_q ? dmem_q : 32'd0;
  assign packet_out_en  = out_en_q;
  assign packet_out_sop = sop_q;
  assign packet_out_eop = eop_q;

`ifdef VOQ_READER_STATS_EN
  logic [31:0] stat_pkts_q,  stat_pkts_d;
  logic [31:0] stat_words_q, stat_words_d;
  logic [15:0] stat_err_q,   stat_err_d;

  always_comb begin
    stat_pkts_d  = stat_pkts_q  + {31'd0, (out_en_q & eop_q)};
    stat_words_d = stat_words_q + {31'd0, out_en_q};
    stat_err_d   = stat_err_q   + {15'd0, grant_err};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pkts_q  <= '0;
      stat_words_q <= '0;
      stat_err_q   <= '0;
    end else begin
      stat_pkts_q  <= stat_pkts_d;
      stat_words_q <= stat_words_d;
      stat_err_q   <= stat_err_d;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_words = stat_words_q;
  assign stat_err   = stat_err_q;
`endif

endmodule
